// File: rtl/operand_bypass_net.sv
// Operand bypass network: tracks in-flight destination tags and resolves each
// decode-stage source to the youngest forwarded result or register-file data.
module operand_bypass_net #(
  parameter int WIDTH    = 32,
  parameter int REGW     = 5,
  parameter int NSRC     = 2,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(NSTAGE+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_vld,
  input  logic [REGW-1:0]          iss_dst,
  input  logic                     iss_we,
  input  logic                     iss_load,
  input  logic                     flush,
  input  logic [NSRC*REGW-1:0]     src_reg,
  input  logic [NSRC-1:0]          src_used,
  input  logic [NSRC*WIDTH-1:0]    rf_data,
  input  logic [NSTAGE*WIDTH-1:0]  stage_data,
  output logic [NSRC*WIDTH-1:0]    src_data,
  output logic [NSRC*SELW-1:0]     src_sel,
  output logic                     stall,
  output logic [15:0]              stall_cnt
);

  logic [NSTAGE-1:0] tv;
  logic [NSTAGE-1:0] tl;
  logic [REGW-1:0]   td [NSTAGE];
  logic [NSRC-1:0]   hazard;
  logic [NSRC-1:0]   found;
  logic              accept;

  // Scan stages youngest-first; the first hit decides, older hits are ignored
  // even when the winner is a load that is not ready yet.
  always_comb begin
    src_data = rf_data;
    src_sel  = '0;
    hazard   = '0;
    found    = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found[i] && src_used[i] && tv[k] &&
            (td[k] == src_reg[i*REGW +: REGW]) &&
            (src_reg[i*REGW +: REGW] != '0)) begin
          found[i] = 1'b1;
          if (tl[k] && (k < LOAD_LAT)) begin
            hazard[i] = 1'b1;
          end else begin
            src_sel[i*SELW +: SELW]   = SELW'(k + 1);
            src_data[i*WIDTH +: WIDTH] = stage_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign stall  = iss_vld & (|hazard);
  assign accept = iss_vld & ~stall & ~flush;

  // Downstream never stalls, so older stages always advance; stage 0 takes a
  // bubble whenever the decode instruction is not accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv        <= '0;
      tl        <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < NSTAGE; k++) td[k] <= '0;
    end else begin
      for (int k = NSTAGE-1; k > 0; k--) begin
        tv[k] <= tv[k-1];
        tl[k] <= tl[k-1];
        td[k] <= td[k-1];
      end
      if (accept) begin
        tv[0] <= iss_we;
        tl[0] <= iss_load;
        td[0] <= iss_dst;
      end else begin
        tv[0] <= 1'b0;
        tl[0] <= 1'b0;
        td[0] <= '0;
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_bypass_net.sv
// Randomised and directed bench for operand_bypass_net against an in-flight
// instruction list model, plus a deep-load instance for counter saturation.
module tb_operand_bypass_net;
  localparam int W  = 32;
  localparam int R  = 5;
  localparam int NS = 2;
  localparam int NT = 3;
  localparam int LL = 1;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             iss_vld, iss_we, iss_load, flush;
  logic [R-1:0]     iss_dst;
  logic [NS*R-1:0]  src_reg;
  logic [NS-1:0]    src_used;
  logic [NS*W-1:0]  rf_data;
  logic [NT*W-1:0]  stage_data;
  logic [NS*W-1:0]  src_data;
  logic [NS*SW-1:0] src_sel;
  logic             stall;
  logic [15:0]      stall_cnt;

  operand_bypass_net #(.WIDTH(W), .REGW(R), .NSRC(NS), .NSTAGE(NT), .LOAD_LAT(LL)) u_dut (
    .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_dst(iss_dst), .iss_we(iss_we),
    .iss_load(iss_load), .flush(flush), .src_reg(src_reg), .src_used(src_used),
    .rf_data(rf_data), .stage_data(stage_data), .src_data(src_data),
    .src_sel(src_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  // deep load latency: a single load hazards for 16 of every 17 cycles
  logic         s_vld;
  logic [4:0]   s_reg;
  logic [0:0]   s_used;
  logic [7:0]   s_rf;
  logic [127:0] s_stage;
  logic [7:0]   s_data;
  logic [4:0]   s_sel;
  logic         s_stall;
  logic [15:0]  s_cnt;

  operand_bypass_net #(.WIDTH(8), .REGW(5), .NSRC(1), .NSTAGE(16), .LOAD_LAT(16)) u_sat (
    .clk(clk), .rst(rst), .iss_vld(s_vld), .iss_dst(5'd9), .iss_we(1'b1),
    .iss_load(1'b1), .flush(1'b0), .src_reg(s_reg), .src_used(s_used),
    .rf_data(s_rf), .stage_data(s_stage), .src_data(s_data),
    .src_sel(s_sel), .stall(s_stall), .stall_cnt(s_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // model: list of in-flight instructions, index 0 = youngest (EX)
  bit         mv [NT];
  logic [R-1:0] md [NT];
  bit         ml [NT];
  int         mcnt;
  bit         m_stall;

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin mv[k] = 0; md[k] = '0; ml[k] = 0; end
    mcnt = 0;
  endtask

  function automatic void resolve(input int i, output int sel, output logic [W-1:0] data, output bit haz);
    logic [R-1:0] r;
    r    = src_reg[i*R +: R];
    sel  = 0;
    data = rf_data[i*W +: W];
    haz  = 0;
    if (!src_used[i] || r == 0) return;
    for (int k = 0; k < NT; k++) begin
      if (mv[k] && md[k] == r) begin
        if (ml[k] && k < LL) haz = 1;
        else begin sel = k + 1; data = stage_data[k*W +: W]; end
        return;
      end
    end
  endfunction

  task automatic look();
    int sel;
    logic [W-1:0] d;
    bit h;
    @(negedge clk);
    m_stall = 0;
    for (int i = 0; i < NS; i++) begin
      resolve(i, sel, d, h);
      chk($sformatf("sel%0d", i), src_sel[i*SW +: SW], sel);
      chk($sformatf("data%0d", i), src_data[i*W +: W], d);
      m_stall |= h;
    end
    m_stall &= iss_vld;
    chk("stall", stall, m_stall);
    chk("stall_cnt", stall_cnt, mcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = NT-1; k > 0; k--) begin mv[k] = mv[k-1]; md[k] = md[k-1]; ml[k] = ml[k-1]; end
    if (iss_vld && !m_stall && !flush) begin mv[0] = iss_we; md[0] = iss_dst; ml[0] = iss_load; end
    else begin mv[0] = 0; md[0] = '0; ml[0] = 0; end
    if (m_stall && mcnt < 16'hFFFF) mcnt++;
    #1;
    rf_data    = {$urandom, $urandom};
    stage_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic iss(input bit v, input logic [R-1:0] d, input bit we, input bit ld);
    iss_vld = v; iss_dst = d; iss_we = we; iss_load = ld;
  endtask

  task automatic src(input int i, input logic [R-1:0] r, input bit u);
    src_reg[i*R +: R] = r;
    src_used[i]       = u;
  endtask

  initial begin
    int n_st;
    rst = 1'b1;
    iss(0, 0, 0, 0); flush = 0; src_reg = '0; src_used = '0;
    rf_data = {$urandom, $urandom}; stage_data = '0;
    s_vld = 0; s_reg = 5'd9; s_used = 1'b1; s_rf = 8'h5A; s_stage = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset asserted while a load-use hazard is live
    iss(1, 3, 1, 1); look(); tick();
    iss(1, 12, 1, 0); src(0, 3, 1);
    look();
    chk("pre_rst_stall", stall, 1);
    rst = 1'b1; #1;
    chk("rst_stall", stall, 0);
    chk("rst_sel", src_sel, 0);
    chk("rst_data", src_data, rf_data);
    chk("rst_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    iss(0, 0, 0, 0); src(0, 0, 0); src(1, 0, 0);

    // EX forward on the first issue after reset
    iss(1, 5, 1, 0); look(); tick();
    iss(1, 7, 1, 0); src(0, 5, 1); src(1, 6, 1);
    stage_data[W-1:0] = 32'h0000_1234;
    look();
    chk("ex_sel0", src_sel[SW-1:0], 1);
    chk("ex_data0", src_data[W-1:0], 32'h0000_1234);
    chk("ex_sel1", src_sel[2*SW-1:SW], 0);
    tick();

    // youngest match wins, then older stage when youngest writes elsewhere
    src(0, 0, 0); src(1, 0, 0);
    iss(1, 1, 1, 0); look(); tick();
    iss(1, 7, 1, 0); look(); tick();
    iss(0, 0, 0, 0); src(0, 7, 1);
    stage_data[W-1:0] = 32'hAAAA; stage_data[2*W +: W] = 32'hBBBB;
    look();
    chk("prio_sel_ex", src_sel[SW-1:0], 1);
    chk("prio_data_ex", src_data[W-1:0], 32'hAAAA);
    tick();
    src(0, 0, 0);
    iss(1, 7, 1, 0); look(); tick();
    iss(1, 2, 1, 0); look(); tick();
    iss(1, 8, 1, 0); look(); tick();
    iss(0, 0, 0, 0); src(0, 7, 1);
    stage_data[W-1:0] = 32'hAAAA; stage_data[2*W +: W] = 32'hBBBB;
    look();
    chk("prio_sel_wb", src_sel[SW-1:0], 3);
    chk("prio_data_wb", src_data[W-1:0], 32'hBBBB);
    tick();

    // load-use: one stall cycle, then forward from MEM
    src(0, 0, 0);
    iss(1, 9, 1, 1); look(); tick();
    iss(1, 10, 0, 0); src(1, 9, 1);
    look();
    chk("lu_stall", stall, 1);
    tick();
    look();
    chk("lu_stall_drop", stall, 0);
    chk("lu_sel1", src_sel[2*SW-1:SW], 2);
    chk("lu_data1", src_data[2*W-1:W], stage_data[2*W-1:W]);
    chk("lu_cnt", stall_cnt, 1);
    tick();

    // r0 never forwards; unused sources never stall
    src(1, 0, 0);
    iss(1, 0, 1, 0); look(); tick();
    iss(1, 4, 1, 1); src(0, 0, 1); look();
    chk("r0_sel", src_sel[SW-1:0], 0);
    chk("r0_stall", stall, 0);
    tick();
    iss(1, 13, 1, 0); src(0, 4, 0); src(1, 4, 0); look();
    chk("unused_stall", stall, 0);
    tick();

    // flushed issue leaves a bubble
    src(0, 0, 0); src(1, 0, 0);
    iss(1, 11, 1, 0); flush = 1; look(); tick();
    flush = 0; iss(0, 0, 0, 0); src(0, 11, 1); look();
    chk("flush_sel", src_sel[SW-1:0], 0);
    tick();

    // randomised traffic over a small register set to provoke matches
    for (int n = 0; n < 400; n++) begin
      iss($urandom_range(0, 3) != 0, R'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NS; i++) src(i, R'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      look();
      tick();
    end
    iss(0, 0, 0, 0); flush = 0;

    // saturation: 16'hFFFE stall cycles then 3 more
    s_vld = 1;
    n_st  = 0;
    for (int c = 0; c < 80000 && n_st < 32'h10001; c++) begin
      @(negedge clk);
      if (c < 100 || c % 997 == 0) chk("sat_stall", s_stall, (c % 17) != 0);
      if (n_st == 32'hFFFE) chk("sat_cnt_fffe", s_cnt, 16'hFFFE);
      @(posedge clk);
      if ((c % 17) != 0) n_st++;
    end
    @(negedge clk);
    chk("sat_reached", n_st, 32'h10001);
    chk("sat_cnt", s_cnt, 16'hFFFF);
    s_vld = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_bypass_net.md
Name: operand_bypass_net

Overview:
- Parametrised successor to the fixed 3-input ALU-operand and 2-input compare-operand forwarding muxes in the pipelined CPU datapath.
- Keeps its own registered pipeline of in-flight destination tags for NSTAGE stages past decode, one stage per clock.
- Compares them against NSRC decode-stage source registers and selects the youngest forwarded value, falling back to register-file data.
- Detects load-use hazards and drives the decode stall, inserting a bubble into its tag pipeline.

Parameters:
- WIDTH, 32, data width of operands and stage results.
- REGW, 5, register-index width.
- NSRC, 2, number of source operands resolved per cycle.
- NSTAGE, 3, tracked stages; stage 0 = EX, stage 1 = MEM, stage 2 = WB.
- LOAD_LAT, 1, first stage index at which a load's result is valid on stage_data.
- SELW, $clog2(NSTAGE+1), width of each per-source select code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- iss_vld  in  1  decode stage holds a valid instruction.
- iss_dst  in  REGW  destination register of the issuing instruction.
- iss_we  in  1  issuing instruction writes iss_dst.
- iss_load  in  1  issuing instruction is a load.
- flush  in  1  squash the decode-stage instruction this cycle.
- src_reg  in  NSRC*REGW  source register indices; source i at bits [i*REGW +: REGW].
- src_used  in  NSRC  source i is actually read by the instruction.
- rf_data  in  NSRC*WIDTH  register-file read data per source.
- stage_data  in  NSTAGE*WIDTH  result bus of each stage; stage k at bits [k*WIDTH +: WIDTH].
- src_data  out  NSRC*WIDTH  resolved operand per source.
- src_sel  out  NSRC*SELW  per source: 0 = register file, k+1 = forwarded from stage k.
- stall  out  1  load-use hazard; decode must hold.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- Tag pipeline: per stage k, registers tv[k] (write valid), td[k] (REGW bits), tl[k] (is load).
- Reset (async, rst=1): all tv, tl = 0; td = 0; stall_cnt = 0.
- While in reset: stall = 0, src_sel = 0, src_data = rf_data.
- Match rule: source i matches stage k when src_used[i] = 1, tv[k] = 1, td[k] = src_reg[i], and src_reg[i] != 0.
  - Register 0 is never forwarded and never stalls.
- Priority: lowest matching k (youngest) wins.
- Forwarded result (winner k with tl[k]=0, or with k >= LOAD_LAT):
  - src_sel[i] = k+1; src_data[i] = stage_data[k].
- Load-use hazard (winner k with tl[k]=1 and k < LOAD_LAT):
  - Source is "hazarded"; src_sel[i] = 0, src_data[i] = rf_data[i] (don't-care).
  - An older matching stage is not used.
- No match: src_sel[i] = 0, src_data[i] = rf_data[i].
- stall = iss_vld & (any source hazarded).
- src_data, src_sel and stall are combinational from registered tags plus inputs; zero latency.
- Clock update, rising edge:
  - Stages 1..NSTAGE-1 always take stage k-1 contents; no hold, since downstream never stalls.
  - Stage 0 loads {iss_we, iss_dst, iss_load} when iss_vld & !stall & !flush.
  - Otherwise stage 0 loads a bubble: tv=0, tl=0, td=0.
  - The oldest stage's tag is discarded.
- flush and stall together: bubble; flush has no other effect, and older stages complete.
- stall_cnt increments when stall=1, saturating at 16'hFFFF; it is not cleared by flush.
- Hazard resolution: a stalled load in stage 0 advances to stage 1 after one cycle.
  - With LOAD_LAT=1, the next cycle forwards from stage 1 and stall drops.
  - Stall length is therefore LOAD_LAT cycles per hazard.
- If reset asserts mid-stall, all tags clear immediately; stall deasserts asynchronously.

Test Plan:
- Reset: rst=1 with a load to r3 in flight and src_reg0=3 -> stall=0, src_sel=0, src_data=rf_data, stall_cnt=0.
  - After release, the first issue enters stage 0 on the next edge.
- EX forward: issue `add r5`, we=1; next cycle source0=r5, stage_data[0]=32'h0000_1234 -> src_sel0=1, src_data0=32'h0000_1234.
  - Source1=r6 -> src_sel1=0.
- Priority: r7 written in stages 0 and 2 (0xAAAA / 0xBBBB), source0=r7 -> src_sel0=1, data 0xAAAA.
  - Same case with stage 0 writing r8 instead -> src_sel0=3, data 0xBBBB.
- Load-use: issue `lw r9`; next cycle source1=r9 -> stall=1 for exactly 1 cycle, stall_cnt=1.
  - Stage 0 holds a bubble; the following cycle src_sel1=2, data=stage_data[1].
- r0 and unused: stage 0 writes r0 and source0=r0 -> src_sel0=0, stall=0.
  - Load r4 in stage 0 with src_used=0 for r4 -> stall=0.
- Flush and saturation: flush=1 with a valid issue -> stage 0 becomes a bubble, and a later r-match gives sel 0.
  - Preload 16'hFFFE stall cycles, then stall 3 more -> stall_cnt holds 16'hFFFF.
